// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and the parity helper.
// Both the transmitter and the receiver use this package.
// Build option: UART_TX_PARITY_EN adds the even-parity helper used by the transmitter.
package uart_pkg;

   localparam int   D_BIT   = 8;
   localparam int   SB_TICK = 16;
   localparam logic B_START = 1'b0;
   localparam logic B_STOP  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } state_t;

`ifdef UART_TX_PARITY_EN
   // Even parity: the parity bit makes the count of ones, including itself, even.
   function automatic logic even_parity(input logic [D_BIT-1:0] data);
      return ^data;
   endfunction
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, D_BIT data bits sent LSB first, optional even
// parity bit, and one stop bit. Each bit lasts SB_TICK pulses of the external s_tick.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit after the data.
module uart_tx
   import uart_pkg::state_t;
   import uart_pkg::IDLE;
   import uart_pkg::START;
   import uart_pkg::DATA;
   import uart_pkg::STOP;
`ifdef UART_TX_PARITY_EN
   import uart_pkg::PARITY;
   import uart_pkg::even_parity;
`endif
   import uart_pkg::B_START;
   import uart_pkg::B_STOP;
#(
   parameter int D_BIT   = uart_pkg::D_BIT,
   parameter int SB_TICK = uart_pkg::SB_TICK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_tick,
   input  logic             tx_start,
   input  logic [D_BIT-1:0] d_in,
   output logic             tx,
   output logic             tx_done,
   output logic             busy
);

   localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
   localparam int NW = (D_BIT > 1) ? $clog2(D_BIT) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);

   state_t           state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [NW-1:0]    n_q, n_d;
   logic [D_BIT-1:0] b_q, b_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   // State, counters, shift register and line outputs; reset parks an idle-high line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic: bit timing advances only on s_tick; acceptance happens on any clock.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d = START;
               s_d     = '0;
               n_d     = '0;
               b_d     = d_in;
`ifdef UART_TX_PARITY_EN
               par_d   = even_parity(d_in);
`endif
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end else begin
               s_d = s_q;
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end else begin
                  s_d = s_q + S_ONE;
               end
            end else begin
               s_d = s_q;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end else begin
               s_d = s_q;
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + S_ONE;
               end
            end else begin
               s_d = s_q;
            end
         end
         default: begin
            state_d = IDLE;
            s_d     = '0;
            n_d     = '0;
         end
      endcase
   end

   // Line value for the coming clock follows the next state, so tx stays a clean flop.
   always_comb begin
      tx_d = B_STOP;
      case (state_d)
         IDLE:    tx_d = B_STOP;
         START:   tx_d = B_START;
         DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         STOP:    tx_d = B_STOP;
         default: tx_d = B_STOP;
      endcase
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: D_BIT, 8, data bits per frame.
REQ-002 SHALL have parameter: SB_TICK, 16, s_tick pulses per bit time (16x oversampling).
REQ-003 SHALL have port: clock  input  1  board clock (50 MHz); one clock, all logic on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: s_tick  input  1  one-clock-wide baud tick at 16x baud rate (9600 bps x 16).
REQ-006 SHALL have port: tx_start  input  1  request to send d_in; sampled every clock.
REQ-007 SHALL have port: d_in  input  8  parallel data to transmit.
REQ-008 SHALL have port: tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port: tx_done  output  1  one-clock pulse at end of stop bit.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only with REQ-030 macro), STOP.
REQ-012 SHALL, in IDLE with tx_start=1, capture d_in into shift register, clear tick counter s and bit counter n, enter START on the same edge; tx_start need not coincide with s_tick.
REQ-013 SHALL drive tx=0 from the first clock after the accepting edge through the START bit time.
REQ-014 SHALL hold each bit (start, each data, parity, stop) for exactly SB_TICK s_tick pulses; s counts 0..SB_TICK-1, advances only on s_tick, wraps to 0 at bit boundary.
REQ-015 SHALL send data LSB first, shifting right one position per data bit; n counts 0..D_BIT-1; after bit D_BIT-1 go to PARITY or STOP.
REQ-016 SHALL drive tx=1 during STOP; on its last s_tick return to IDLE and pulse tx_done high for exactly one clock.
REQ-017 SHALL ignore tx_start while busy=1, including the clock on which STOP completes; a new frame starts only from IDLE.
REQ-018 SHALL make a frame last exactly (D_BIT+2)*SB_TICK s_tick pulses, plus SB_TICK with parity.
REQ-019 SHALL keep tx, state and counters unchanged on clocks without s_tick (apart from the REQ-012 acceptance).
REQ-020 SHALL size s to ceil(log2(SB_TICK)) bits and n to ceil(log2(D_BIT)) bits; no arithmetic overflow beyond wrap.
REQ-021 SHALL not alter d_out-side data while in flight: changes on d_in after acceptance have no effect.

Reset
REQ-022 SHALL, on reset asserted, immediately force state IDLE, tx=1, tx_done=0, busy=0, s=0, n=0, shift register 0.
REQ-023 SHALL abort any frame in progress on reset with no tx_done pulse; after release the line stays high until a new tx_start.

Configuration
REQ-030 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state after DATA sending one even-parity bit (XOR of the 8 data bits) for SB_TICK ticks, then STOP.
REQ-031 SHALL, without UART_TX_PARITY_EN, go DATA -> STOP directly and contain no parity logic or state.

Structure
REQ-040 SHALL place state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4 widened to 3 bits) and constants D_BIT, SB_TICK, B_start=0, B_stop=1 in shared package uart_pkg, also used by the receiver.
REQ-041 SHALL be a single module; no sub-module; baud tick generator stays external and shared with the receiver.

Verification
REQ-050 SHALL test: d_in=0x55, tx_start one clock -> tx bits 0,1,0,1,0,1,0,1,0,1, each 16 s_ticks, tx_done one pulse after 160 s_ticks.
REQ-051 SHALL test: d_in=0xA3 with UART_TX_PARITY_EN -> data 1,1,0,0,0,1,0,1 then parity 0, stop 1, total 176 s_ticks.
REQ-052 SHALL test: tx_start pulsed at 40th s_tick of a 0x0F frame with d_in=0xFF -> ignored, frame still sends 0x0F, busy stays 1.
REQ-053 SHALL test: reset asserted at s_tick 70 of a frame -> tx=1 same cycle, busy=0, no tx_done; next tx_start 0x81 sends a clean frame.
REQ-054 SHALL test: back-to-back frames 0x00 then 0xFF with tx_start reasserted the clock after tx_done -> contiguous frames, stop bit exactly 16 s_ticks.
REQ-055 SHALL test: loopback tx into UART receiver for 256 random bytes -> all received bytes equal sent bytes.
